// File: rtl/rom_serial_seq.sv
// Serialises one of four fixed ROM words onto ser_o and reassembles the word from ser_i.
// Define PARITY_SERIAL_EN to append an even-parity bit and expose parity_err.
module rom_serial_seq #(
    parameter int MSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [1:0] sel,
    input  logic       ser_i,
    output logic       ser_o,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data
`ifdef PARITY_SERIAL_EN
    ,
    output logic       parity_err
`endif
);

    localparam bit MSB = (MSB_FIRST != 0);
`ifdef PARITY_SERIAL_EN
    localparam logic [3:0] LAST = 4'd8;
`else
    localparam logic [3:0] LAST = 4'd7;
`endif
    localparam logic [3:0] TERM = LAST + 4'd1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t     state_q;
    logic [1:0] sel_q;
    logic [7:0] tx_q, rx_q, rx_data_q;
    logic [3:0] cnt_q;
    logic       ser_q, busy_q, done_q;
`ifdef PARITY_SERIAL_EN
    logic       par_q, perr_q;
`endif

    logic [7:0] word_d, rx_d, tx_d;
    logic [3:0] cnt_d;

    function automatic logic [7:0] rom_word(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h0F;
            2'd1:    return 8'hAA;
            2'd2:    return 8'hCC;
            default: return 8'hF0;
        endcase
    endfunction

    function automatic logic wire_bit(input logic [7:0] w);
        return MSB ? w[7] : w[0];
    endfunction

    // Receiver fills in the same order the transmitter empties.
    always_comb begin
        word_d = rom_word(sel_q);
        rx_d   = MSB ? {rx_q[6:0], ser_i} : {ser_i, rx_q[7:1]};
        tx_d   = MSB ? {tx_q[6:0], 1'b0}  : {1'b0, tx_q[7:1]};
        cnt_d  = (cnt_q == TERM) ? cnt_q : cnt_q + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= 2'd0;
            tx_q      <= 8'h00;
            rx_q      <= 8'h00;
            rx_data_q <= 8'h00;
            cnt_q     <= 4'd0;
            ser_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef PARITY_SERIAL_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        sel_q   <= sel;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    tx_q    <= word_d;
                    rx_q    <= 8'h00;
                    cnt_q   <= 4'd0;
                    ser_q   <= wire_bit(word_d);
`ifdef PARITY_SERIAL_EN
                    par_q   <= ^word_d;
`endif
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        ser_q   <= 1'b0;
`ifdef PARITY_SERIAL_EN
                        // ser_i now carries the parity bit; rx_q already holds the data.
                        rx_data_q <= rx_q;
                        perr_q    <= ser_i ^ (^rx_q);
`else
                        rx_q      <= rx_d;
                        rx_data_q <= rx_d;
`endif
                    end else begin
                        rx_q <= rx_d;
                        tx_q <= tx_d;
`ifdef PARITY_SERIAL_EN
                        ser_q <= (cnt_q == LAST - 4'd1) ? par_q : wire_bit(tx_d);
`else
                        ser_q <= wire_bit(tx_d);
`endif
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ser_o   = ser_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
`ifdef PARITY_SERIAL_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_rom_serial_seq.sv
// Bench for rom_serial_seq: MSB-first and LSB-first instances in loopback with
// bit-error injection, checked against a wire-level reference model.
module tb_rom_serial_seq;

`ifdef PARITY_SERIAL_EN
    localparam int NB = 9;
    localparam logic [8:0] WMASK = 9'h1FF;
`else
    localparam int NB = 8;
    localparam logic [8:0] WMASK = 9'h0FF;
`endif
    localparam int SP = NB + 3;

    logic       clk = 1'b0;
    logic       rst, req, inj;
    logic [1:0] sel;
    logic       ser_o_m, ser_i_m, busy_m, done_m;
    logic       ser_o_l, ser_i_l, busy_l, done_l;
    logic [7:0] rx_m, rx_l;
`ifdef PARITY_SERIAL_EN
    logic       perr_m, perr_l;
`endif

    int checks = 0;
    int failures = 0;

    assign ser_i_m = ser_o_m ^ inj;
    assign ser_i_l = ser_o_l ^ inj;

    always #5 clk = ~clk;

    rom_serial_seq #(.MSB_FIRST(1)) dut_m (
        .clk(clk), .rst(rst), .req(req), .sel(sel), .ser_i(ser_i_m), .ser_o(ser_o_m),
        .busy(busy_m), .done(done_m), .rx_data(rx_m)
`ifdef PARITY_SERIAL_EN
        , .parity_err(perr_m)
`endif
    );

    rom_serial_seq #(.MSB_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .req(req), .sel(sel), .ser_i(ser_i_l), .ser_o(ser_o_l),
        .busy(busy_l), .done(done_l), .rx_data(rx_l)
`ifdef PARITY_SERIAL_EN
        , .parity_err(perr_l)
`endif
    );

    function automatic logic [7:0] rom_model(input logic [1:0] s);
        logic [7:0] t [4];
        t = '{8'h0F, 8'hAA, 8'hCC, 8'hF0};
        return t[s];
    endfunction

    // Bit i is the i-th bit on the wire; bit 8 is the even-parity bit.
    function automatic logic [8:0] wire_seq(input logic [7:0] w, input bit msb);
        logic [8:0] s;
        for (int i = 0; i < 8; i++) s[i] = msb ? w[7-i] : w[i];
        s[8] = ^w;
        return s;
    endfunction

    function automatic logic [7:0] assemble(input logic [8:0] r, input bit msb);
        logic [7:0] w;
        w = 8'h00;
        for (int i = 0; i < 8; i++) w[msb ? 7-i : i] = r[i];
        return w;
    endfunction

    // Runs one transfer from an idle DUT pair; flip[i] corrupts wire bit i on the receive side.
    task automatic xfer(input logic [1:0] s, input logic [8:0] flip,
                        output logic [8:0] obm, output logic [8:0] obl,
                        output int latm, output int latl, output int npm, output int npl,
                        output int bad);
        logic [7:0] rxm0, rxl0;
        rxm0 = rx_m; rxl0 = rx_l;
        obm = '0; obl = '0; latm = -1; latl = -1; npm = 0; npl = 0; bad = 0;
        req = 1'b1; sel = s;
        @(posedge clk); #1;
        req = 1'b0; sel = 2'($urandom);
        if (busy_m !== 1'b1 || busy_l !== 1'b1 || ser_o_m !== 1'b0 || ser_o_l !== 1'b0) bad++;
        for (int c = 1; c <= NB + 2; c++) begin
            @(posedge clk); #1;
            inj = 1'b0;
            if (c <= NB) begin
                obm[c-1] = ser_o_m; obl[c-1] = ser_o_l; inj = flip[c-1];
                if (rx_m !== rxm0 || rx_l !== rxl0) bad++;
            end else if (ser_o_m !== 1'b0 || ser_o_l !== 1'b0) bad++;
            if (done_m === 1'b1) begin npm++; if (latm < 0) latm = c; end
            if (done_l === 1'b1) begin npl++; if (latl < 0) latl = c; end
            if (busy_m !== 1'(c <= NB + 1) || busy_l !== 1'(c <= NB + 1)) bad++;
        end
        inj = 1'b0;
    endtask

    task automatic test_reset;
        logic [8:0] obm, obl;
        int latm, latl, npm, npl, bad;
        rst = 1'b1; req = 1'b0; sel = 2'd0; inj = 1'b0;
        #12;
        checks++;
        if ({ser_o_m, busy_m, done_m, rx_m, ser_o_l, busy_l, done_l, rx_l} !== 22'd0) begin
            failures++;
            $display("FAIL reset_state got m=%b%b%b/%h l=%b%b%b/%h want all zero",
                     ser_o_m, busy_m, done_m, rx_m, ser_o_l, busy_l, done_l, rx_l);
        end
`ifdef PARITY_SERIAL_EN
        checks++;
        if (perr_m !== 1'b0 || perr_l !== 1'b0) begin
            failures++; $display("FAIL reset_parity got %b/%b want 0", perr_m, perr_l);
        end
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        xfer(2'd3, 9'd0, obm, obl, latm, latl, npm, npl, bad);
        checks++;
        if (latm != NB + 1 || rx_m !== 8'hF0) begin
            failures++; $display("FAIL first_after_reset got lat=%0d rx=%h want %0d/f0", latm, rx_m, NB + 1);
        end
        req = 1'b1; sel = 2'd3;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ser_o_m, busy_m, done_m, rx_m, ser_o_l, busy_l, done_l, rx_l} !== 22'd0) begin
            failures++;
            $display("FAIL reset_midxfer got m=%b%b%b/%h l=%b%b%b/%h want all zero",
                     ser_o_m, busy_m, done_m, rx_m, ser_o_l, busy_l, done_l, rx_l);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_transfer;
        logic [8:0] obm, obl;
        int latm, latl, npm, npl, bad;
        logic [7:0] w;
        w = rom_model(2'd0);
        xfer(2'd0, 9'd0, obm, obl, latm, latl, npm, npl, bad);
        checks++;
        if (latm != NB + 1 || latl != NB + 1) begin
            failures++; $display("FAIL done_latency got %0d/%0d want %0d", latm, latl, NB + 1);
        end
        checks++;
        if (npm != 1 || npl != 1) begin
            failures++; $display("FAIL done_pulses got %0d/%0d want 1", npm, npl);
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL busy_ser_hold got %0d violations want 0", bad);
        end
        checks++;
        if (rx_m !== w || rx_l !== w) begin
            failures++; $display("FAIL rx_sel0 got %h/%h want %h", rx_m, rx_l, w);
        end
    endtask

    task automatic test_order;
        logic [8:0] obm, obl, em, el;
        int latm, latl, npm, npl, bad;
        xfer(2'd1, 9'd0, obm, obl, latm, latl, npm, npl, bad);
        em = wire_seq(rom_model(2'd1), 1'b1);
        el = wire_seq(rom_model(2'd1), 1'b0);
        checks++;
        if ((obm & WMASK) !== (em & WMASK) || obm[7:0] !== 8'h55) begin
            failures++; $display("FAIL order_msb_sel1 got %b want %b", obm, em & WMASK);
        end
        checks++;
        if ((obl & WMASK) !== (el & WMASK)) begin
            failures++; $display("FAIL order_lsb_sel1 got %b want %b", obl, el & WMASK);
        end
        xfer(2'd2, 9'd0, obm, obl, latm, latl, npm, npl, bad);
        el = wire_seq(rom_model(2'd2), 1'b0);
        checks++;
        if ((obl & WMASK) !== (el & WMASK) || obl[7:0] !== 8'hCC) begin
            failures++; $display("FAIL order_lsb_sel2 got %b want %b", obl, el & WMASK);
        end
        checks++;
        if (rx_m !== 8'hCC || rx_l !== 8'hCC) begin
            failures++; $display("FAIL rx_sel2 got %h/%h want cc", rx_m, rx_l);
        end
    endtask

    task automatic test_back_to_back;
        int dm, dl, badt, adj, badrx, last;
        logic expd;
        dm = 0; dl = 0; badt = 0; adj = 0; badrx = 0; last = -100;
        inj = 1'b0; req = 1'b1; sel = 2'd3;
        for (int k = 0; k < 3 * SP; k++) begin
            @(posedge clk); #1;
            expd = 1'((k % SP) == NB + 1);
            if (done_m !== expd || done_l !== expd) badt++;
            if (done_m === 1'b1) begin
                dm++;
                if (k - last == 1) adj++;
                last = k;
                if (rx_m !== 8'hF0 || rx_l !== 8'hF0) badrx++;
            end
            if (done_l === 1'b1) dl++;
            if (k + 1 == 3 * SP) req = 1'b0;
            sel = ((k + 1) % SP == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        end
        checks++;
        if (dm != 3 || dl != 3) begin
            failures++; $display("FAIL b2b_count got %0d/%0d want 3", dm, dl);
        end
        checks++;
        if (badt != 0 || adj != 0) begin
            failures++; $display("FAIL b2b_spacing got %0d misplaced %0d adjacent want 0", badt, adj);
        end
        checks++;
        if (badrx != 0) begin
            failures++; $display("FAIL b2b_rx got %0d wrong words want 0 (f0)", badrx);
        end
    endtask

    task automatic test_abort;
        logic [8:0] obm, obl;
        int latm, latl, npm, npl, bad, spur;
        spur = 0;
        @(posedge clk); #3 rst = 1'b1;
        #4 rst = 1'b0;
        @(posedge clk); #1;
        req = 1'b1; sel = 2'd1;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (busy_m !== 1'b0 || done_m !== 1'b0 || ser_o_m !== 1'b0 || busy_l !== 1'b0) begin
            failures++; $display("FAIL abort_immediate got busy=%b done=%b ser=%b want 0", busy_m, done_m, ser_o_m);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < SP; c++) begin
            @(posedge clk); #1;
            if (done_m !== 1'b0 || done_l !== 1'b0 || rx_m !== 8'h00 || rx_l !== 8'h00) spur++;
        end
        checks++;
        if (spur != 0) begin
            failures++; $display("FAIL abort_no_done got %0d bad cycles rx=%h want 0/00", spur, rx_m);
        end
        xfer(2'd2, 9'd0, obm, obl, latm, latl, npm, npl, bad);
        checks++;
        if (rx_m !== 8'hCC || rx_l !== 8'hCC || npm != 1) begin
            failures++; $display("FAIL abort_recover got %h/%h pulses=%0d want cc/cc/1", rx_m, rx_l, npm);
        end
    endtask

    task automatic test_random;
        logic [8:0] obm, obl, em, el, flip;
        logic [7:0] xm, xl;
        logic [1:0] s;
        int latm, latl, npm, npl, bad;
        for (int t = 0; t < 16; t++) begin
            s = 2'($urandom);
            flip = ($urandom % 2 == 0) ? 9'd0 : (9'($urandom) & WMASK);
            em = wire_seq(rom_model(s), 1'b1);
            el = wire_seq(rom_model(s), 1'b0);
            xm = assemble(em ^ flip, 1'b1);
            xl = assemble(el ^ flip, 1'b0);
            xfer(s, flip, obm, obl, latm, latl, npm, npl, bad);
            checks++;
            if ((obm & WMASK) !== (em & WMASK) || (obl & WMASK) !== (el & WMASK)) begin
                failures++; $display("FAIL rand%0d_wire got %b/%b want %b/%b", t, obm, obl, em & WMASK, el & WMASK);
            end
            checks++;
            if (rx_m !== xm || rx_l !== xl) begin
                failures++; $display("FAIL rand%0d_rx got %h/%h want %h/%h", t, rx_m, rx_l, xm, xl);
            end
            checks++;
            if (latm != NB + 1 || npm != 1 || npl != 1 || bad != 0) begin
                failures++; $display("FAIL rand%0d_timing got lat=%0d pulses=%0d/%0d viol=%0d want %0d/1/1/0",
                                     t, latm, npm, npl, bad, NB + 1);
            end
`ifdef PARITY_SERIAL_EN
            checks++;
            if (perr_m !== 1'(^(em ^ flip)) || perr_l !== 1'(^(el ^ flip))) begin
                failures++; $display("FAIL rand%0d_parity got %b/%b want %b", t, perr_m, perr_l, ^(em ^ flip));
            end
`endif
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
    endtask

`ifdef PARITY_SERIAL_EN
    task automatic test_parity;
        logic [8:0] obm, obl;
        int latm, latl, npm, npl, bad;
        xfer(2'd1, 9'd0, obm, obl, latm, latl, npm, npl, bad);
        checks++;
        if (perr_m !== 1'b0 || perr_l !== 1'b0 || latm != 10) begin
            failures++; $display("FAIL parity_clean got %b/%b lat=%0d want 0/0/10", perr_m, perr_l, latm);
        end
        xfer(2'd1, 9'h100, obm, obl, latm, latl, npm, npl, bad);
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (perr_m !== 1'b1 || perr_l !== 1'b1 || rx_m !== 8'hAA || rx_l !== 8'hAA) begin
            failures++; $display("FAIL parity_flip got %b/%b rx=%h/%h want 1/1/aa", perr_m, perr_l, rx_m, rx_l);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_transfer;
        test_order;
        test_back_to_back;
        test_abort;
        test_random;
`ifdef PARITY_SERIAL_EN
        test_parity;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
